// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART 8N1 transmitter with an integrated baud divider and a
// byte FIFO in front of it. Upstream pushes bytes with wr_valid/wr_ready. The
// bytes go out on rs232_tx LSB first, with no idle gap between queued frames.
//
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit, so a frame is 11 bit times instead of 10.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   wr_data    byte to transmit
//   wr_valid   wr_data is valid this cycle
//   wr_ready   FIFO can accept a byte (not full)
//   rs232_tx   serial line, idle high, registered
//   busy       frame on the line or FIFO non-empty
//   fifo_count bytes currently stored, 0..2^FIFO_AW
//   tx_done    one-cycle pulse during the last clock of each stop bit
//
// state  | meaning
// IDLE   | line high, waiting for a byte in the FIFO
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit (high); pops the next byte at its end if one is queued

module uart_tx_fifo #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int FIFO_AW  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic               rs232_tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               tx_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int DEPTH    = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [7:0]         mem_q [DEPTH];
`ifdef UART_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    logic fifo_empty, fifo_full, wr_en, pop, bit_end;
    logic [7:0] head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (FIFO_AW+1)'(DEPTH));
    // Fullness is judged before the edge, so a pop on the same edge never
    // frees room for a write.
    assign wr_en      = wr_valid && !fifo_full;
    assign head       = mem_q[rd_ptr_q];
    assign bit_end    = (cnt_q == CW'(BAUD_DIV - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_end ? '0 : cnt_q + CW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop      = 1'b0;
        tx_done  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = START;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tx_done = 1'b1;
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = START;
                        tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop)
            count_d = count_q + (FIFO_AW+1)'(1);
        else if (!wr_en && pop)
            count_d = count_q - (FIFO_AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Storage needs no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            mem_q[wr_ptr_q] <= wr_data;
    end

    assign wr_ready   = !fifo_full;
    assign rs232_tx   = tx_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign fifo_count = count_q;

endmodule
